// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : alu_pkg
//  Purpose  : Shared ALU opcode and RV32I encoding constants, used by the
//             instruction decode stage and by the ALU itself.
//  Contents : 6-bit ALU op codes, RV32I major opcodes, funct7 variants.
//  Revision : 1.0  initial release
// ============================================================================
package alu_pkg;

  // ALU operation codes. For the base R/I-type group the op equals funct3.
  localparam logic [5:0] OP_ADD  = 6'd0;
  localparam logic [5:0] OP_SLL  = 6'd1;
  localparam logic [5:0] OP_SLT  = 6'd2;
  localparam logic [5:0] OP_SLTU = 6'd3;
  localparam logic [5:0] OP_XOR  = 6'd4;
  localparam logic [5:0] OP_SRL  = 6'd5;
  localparam logic [5:0] OP_OR   = 6'd6;
  localparam logic [5:0] OP_AND  = 6'd7;
  localparam logic [5:0] OP_SRA  = 6'd8;
  localparam logic [5:0] OP_SUB  = 6'd9;

  // RV32I major opcodes handled by this decoder.
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;

  // funct7 variants.
  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

endpackage : alu_pkg
`default_nettype wire

// File: rtl/alu_op_dec.sv
`default_nettype none
// ============================================================================
//  Module   : alu_op_dec
//  Purpose  : Purely combinational RV32I decode: ALU op, immediate operand
//             and legality of the instruction word.
//  Ports    : instr_i     32-bit instruction word
//             op_o        ALU opcode (alu_pkg OP_*)
//             legal_o     instruction is a supported R/OP-IMM/LUI encoding
//             use_imm_o   second operand comes from imm_o
//             zero_rv1_o  first operand forced to zero (LUI)
//             imm_o       decoded immediate
//  Revision : 1.0  initial release
// ============================================================================
module alu_op_dec
  import alu_pkg::*;
(
  input  logic [31:0] instr_i,
  output logic [5:0]  op_o,
  output logic        legal_o,
  output logic        use_imm_o,
  output logic        zero_rv1_o,
  output logic [31:0] imm_o
);

  logic [6:0]  w_opcode;
  logic [2:0]  w_funct3;
  logic [6:0]  w_funct7;
  logic [31:0] w_imm_i;
  logic [31:0] w_shamt;
  logic        w_unused_rd;

  assign w_opcode = instr_i[6:0];
  assign w_funct3 = instr_i[14:12];
  assign w_funct7 = instr_i[31:25];
  assign w_imm_i  = {{20{instr_i[31]}}, instr_i[31:20]};
  assign w_shamt  = {27'b0, instr_i[24:20]};

  // Destination field is extracted by the parent, not needed here.
  assign w_unused_rd = ^instr_i[11:7];

  always_comb begin
    op_o       = OP_ADD;
    legal_o    = 1'b0;
    use_imm_o  = 1'b0;
    zero_rv1_o = 1'b0;
    imm_o      = w_imm_i;
    case (w_opcode)
      OPC_OP: begin
        if (w_funct7 == F7_BASE) begin
          legal_o = 1'b1;
          op_o    = {3'b000, w_funct3};
        end else if (w_funct7 == F7_ALT && w_funct3 == 3'b000) begin
          legal_o = 1'b1;
          op_o    = OP_SUB;
        end else if (w_funct7 == F7_ALT && w_funct3 == 3'b101) begin
          legal_o = 1'b1;
          op_o    = OP_SRA;
        end
      end
      OPC_OP_IMM: begin
        use_imm_o = 1'b1;
        case (w_funct3)
          // Shift-immediates: upper bits of the immediate are funct7.
          3'b001: begin
            imm_o   = w_shamt;
            op_o    = OP_SLL;
            legal_o = (w_funct7 == F7_BASE);
          end
          3'b101: begin
            imm_o = w_shamt;
            if (w_funct7 == F7_BASE) begin
              op_o    = OP_SRL;
              legal_o = 1'b1;
            end else if (w_funct7 == F7_ALT) begin
              op_o    = OP_SRA;
              legal_o = 1'b1;
            end
          end
          default: begin
            op_o    = {3'b000, w_funct3};
            legal_o = 1'b1;
          end
        endcase
      end
      OPC_LUI: begin
        legal_o    = 1'b1;
        use_imm_o  = 1'b1;
        zero_rv1_o = 1'b1;
        imm_o      = {instr_i[31:12], 12'b0};
      end
      default: ;
    endcase
  end

endmodule : alu_op_dec
`default_nettype wire

// File: rtl/alu_decode.sv
`default_nettype none
// ============================================================================
//  Module   : alu_decode
//  Purpose  : RV32I decode/issue stage in front of the ALU. Accepts one
//             instruction per valid/ready handshake, reads operands, and
//             presents a registered ALU operation. Illegal encodings are
//             dropped and counted in a saturating counter.
//  Ports    : clk, reset_n (async, active-low)
//             in_valid/in_ready/instr/flush      upstream instruction side
//             rs1_addr/rs2_addr/rs1_data/rs2_data register-file read port
//             wb_en/wb_rd/wb_data                writeback (bypass source)
//             out_valid/out_ready/op/rv1/rv2/rd/rd_we  ALU issue side
//             illegal_flag/illegal_cnt           sticky illegal status
//  Config   : define ALU_DECODE_BYPASS_EN to forward writeback data into
//             the operands; otherwise wb_* inputs are ignored.
//  Revision : 1.0  initial release
// ============================================================================
module alu_decode
  import alu_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instr,
  input  logic             flush,
  output logic [4:0]       rs1_addr,
  output logic [4:0]       rs2_addr,
  input  logic [31:0]      rs1_data,
  input  logic [31:0]      rs2_data,
  input  logic             wb_en,
  input  logic [4:0]       wb_rd,
  input  logic [31:0]      wb_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [5:0]       op,
  output logic [31:0]      rv1,
  output logic [31:0]      rv2,
  output logic [4:0]       rd,
  output logic             rd_we,
  output logic             illegal_flag,
  output logic [CNT_W-1:0] illegal_cnt
);

  logic [5:0]  w_dec_op;
  logic        w_dec_legal;
  logic        w_dec_use_imm;
  logic        w_dec_zero_rv1;
  logic [31:0] w_dec_imm;
  logic [31:0] w_opa;
  logic [31:0] w_opb;
  logic        w_accept;

  logic             out_valid_q, out_valid_d;
  logic [5:0]       op_q, op_d;
  logic [31:0]      rv1_q, rv1_d;
  logic [31:0]      rv2_q, rv2_d;
  logic [4:0]       rd_q, rd_d;
  logic             rd_we_q, rd_we_d;
  logic             illegal_flag_q, illegal_flag_d;
  logic [CNT_W-1:0] illegal_cnt_q, illegal_cnt_d;

  alu_op_dec u_op_dec (
    .instr_i    (instr),
    .op_o       (w_dec_op),
    .legal_o    (w_dec_legal),
    .use_imm_o  (w_dec_use_imm),
    .zero_rv1_o (w_dec_zero_rv1),
    .imm_o      (w_dec_imm)
  );

  assign rs1_addr = instr[19:15];
  assign rs2_addr = instr[24:20];
  assign in_ready = !out_valid_q || out_ready;
  // flush suppresses any accept in the same cycle.
  assign w_accept = in_valid && in_ready && !flush;

  // Operand read with optional writeback forwarding; x0 always reads zero.
  always_comb begin
    w_opa = rs1_data;
    w_opb = rs2_data;
`ifdef ALU_DECODE_BYPASS_EN
    if (wb_en && wb_rd == rs1_addr) w_opa = wb_data;
    if (wb_en && wb_rd == rs2_addr) w_opb = wb_data;
`endif
    if (rs1_addr == 5'd0) w_opa = 32'd0;
    if (rs2_addr == 5'd0) w_opb = 32'd0;
  end

`ifndef ALU_DECODE_BYPASS_EN
  logic w_unused_wb;
  assign w_unused_wb = ^{wb_en, wb_rd, wb_data};
`endif

  always_comb begin
    out_valid_d    = out_valid_q;
    op_d           = op_q;
    rv1_d          = rv1_q;
    rv2_d          = rv2_q;
    rd_d           = rd_q;
    rd_we_d        = rd_we_q;
    illegal_flag_d = illegal_flag_q;
    illegal_cnt_d  = illegal_cnt_q;
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (w_accept && w_dec_legal) begin
      out_valid_d = 1'b1;
      op_d        = w_dec_op;
      rv1_d       = w_dec_zero_rv1 ? 32'd0 : w_opa;
      rv2_d       = w_dec_use_imm ? w_dec_imm : w_opb;
      rd_d        = instr[11:7];
      rd_we_d     = (instr[11:7] != 5'd0);
    end else begin
      // An illegal accept still lets a held operation drain.
      if (out_ready) out_valid_d = 1'b0;
      if (w_accept) begin
        illegal_flag_d = 1'b1;
        if (illegal_cnt_q != {CNT_W{1'b1}}) illegal_cnt_d = illegal_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_q    <= 1'b0;
      op_q           <= 6'd0;
      rv1_q          <= 32'd0;
      rv2_q          <= 32'd0;
      rd_q           <= 5'd0;
      rd_we_q        <= 1'b0;
      illegal_flag_q <= 1'b0;
      illegal_cnt_q  <= '0;
    end else begin
      out_valid_q    <= out_valid_d;
      op_q           <= op_d;
      rv1_q          <= rv1_d;
      rv2_q          <= rv2_d;
      rd_q           <= rd_d;
      rd_we_q        <= rd_we_d;
      illegal_flag_q <= illegal_flag_d;
      illegal_cnt_q  <= illegal_cnt_d;
    end
  end

  assign out_valid    = out_valid_q;
  assign op           = op_q;
  assign rv1          = rv1_q;
  assign rv2          = rv2_q;
  assign rd           = rd_q;
  assign rd_we        = rd_we_q;
  assign illegal_flag = illegal_flag_q;
  assign illegal_cnt  = illegal_cnt_q;

endmodule : alu_decode
`default_nettype wire
